// File: rtl/irq_pending_latch.sv
// Interrupt front end: edge/level capture into a pending register, masked
// presentation to an external priority encoder, one-at-a-time CPU handshake.
module irq_pending_latch #(
  parameter bit RISING_EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  output logic [7:0] req_vec,
  input  logic [2:0] enc_y,
  input  logic       enc_valid,
  output logic [7:0] pending,
  output logic       int_req,
  output logic [2:0] int_vec,
  input  logic       int_ack
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_irqPrev;
  logic [7:0] r_pending;
  logic [2:0] r_intVec;
  logic [7:0] w_set;
  logic [7:0] w_clr;
  logic       w_ackFire;
  logic       w_capture;

  // Tracks the previous sample of irq_in even during reset, so lines already
  // high across reset release are not mistaken for fresh edges.
  always_ff @(posedge clk) begin
    r_irqPrev <= irq_in;
  end

  always_comb begin
    if (RISING_EDGE) begin
      w_set = irq_in & ~r_irqPrev;
    end else begin
      w_set = irq_in;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_ackFire   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enc_valid) begin
          w_nextState = S_REQ;
          w_capture   = 1'b1;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          w_nextState = S_IDLE;
          w_ackFire   = 1'b1;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Clear only the serviced line; a simultaneous new set on it survives.
  always_comb begin
    w_clr = 8'h00;
    if (w_ackFire) begin
      w_clr = 8'h01 << r_intVec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= 8'h00;
      r_intVec  <= 3'd0;
    end else begin
      r_state   <= w_nextState;
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_capture) begin
        r_intVec <= enc_y;
      end
    end
  end

  assign req_vec = r_pending & mask;
  assign pending = r_pending;
  assign int_req = (r_state == S_REQ);
  assign int_vec = r_intVec;

endmodule
